// File: rtl/prra_pkg.sv
// Shared helpers for the pseudo round-robin arbiter: next-grant function and parameter legality check.
package prra_pkg;

  localparam int unsigned PRRA_MAX_WIDTH = 16;

  // Next grant after current holder s: scan s+1, s+2, ... wrapping, with s itself checked last.
  function automatic int unsigned prra_next(input int unsigned r,
                                            input int unsigned s,
                                            input int unsigned width);
    int unsigned idx;
    int unsigned res;
    logic        found;
    res   = s;
    found = 1'b0;
    for (int unsigned k = 1; k <= width; k++) begin
      idx = (s + k) % width;
      if (!found && (((r >> idx) & 32'd1) != 32'd0)) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic prra_params_ok(input int unsigned width,
                                          input int unsigned log2_width,
                                          input int unsigned state_offset);
    return (width >= 2) && (width <= PRRA_MAX_WIDTH) &&
           ((32'd1 << log2_width) >= width) && (state_offset < width);
  endfunction

endpackage

// File: rtl/prra_lut_reg.sv
// Per-state next-grant lookup: constant table indexed by the request vector, registered output.
module prra_lut_reg
  import prra_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned LOG2_WIDTH   = 2,
  parameter int unsigned STATE_OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      request,
  output logic [LOG2_WIDTH-1:0] state
);

  localparam int unsigned DEPTH = 32'd1 << WIDTH;

  if (!prra_params_ok(WIDTH, LOG2_WIDTH, STATE_OFFSET)) begin : g_param_check
    $error("prra_lut_reg: illegal WIDTH=%0d LOG2_WIDTH=%0d STATE_OFFSET=%0d",
           WIDTH, LOG2_WIDTH, STATE_OFFSET);
  end

  // Constant table, one entry per request pattern.
  logic [LOG2_WIDTH-1:0] lut [DEPTH];

  for (genvar j = 0; j < DEPTH; j++) begin : g_lut
    assign lut[j] = LOG2_WIDTH'(prra_next(32'(j), STATE_OFFSET, WIDTH));
  end

  logic [LOG2_WIDTH-1:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOG2_WIDTH'(STATE_OFFSET);
    else     r_state <= lut[request];
  end

  assign state = r_state;

endmodule

// File: tb/tb_prra_lut_reg.sv
// Directed bench for prra_lut_reg: three parameterisations checked through a scoreboard of expected grants.
module tb_prra_lut_reg;

  logic       clk;
  logic       rst;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [4:0] req_c;
  logic [1:0] state_a;
  logic [1:0] state_b;
  logic [2:0] state_c;

  int n_pass  = 0;
  int n_total = 0;
  int max_c   = 0;

  int qa[$];
  int qb[$];
  int qc[$];

  prra_lut_reg #(.WIDTH(4), .LOG2_WIDTH(2), .STATE_OFFSET(1)) u_a (
    .clk(clk), .rst(rst), .request(req_a), .state(state_a));
  prra_lut_reg #(.WIDTH(4), .LOG2_WIDTH(2), .STATE_OFFSET(3)) u_b (
    .clk(clk), .rst(rst), .request(req_b), .state(state_b));
  prra_lut_reg #(.WIDTH(5), .LOG2_WIDTH(3), .STATE_OFFSET(4)) u_c (
    .clk(clk), .rst(rst), .request(req_c), .state(state_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rotate so the scan starts at s+1, then take the lowest set bit.
  function automatic int m_next(input int r, input int s, input int w);
    int start;
    int mask;
    int rot;
    int low;
    if (r == 0) return s;
    start = (s + 1) % w;
    mask  = (1 << w) - 1;
    rot   = ((r >> start) | (r << (w - start))) & mask;
    low   = rot & (-rot);
    return (start + $clog2(low)) % w;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drive at a falling edge, push expectations, compare after the next rising edge.
  task automatic step(input logic [3:0] ra, input int ea,
                      input logic [3:0] rb, input int eb,
                      input logic [4:0] rc, input int ec);
    int e;
    req_a = ra; req_b = rb; req_c = rc;
    qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
    @(posedge clk);
    @(negedge clk);
    e = qa.pop_front(); chk($sformatf("a_req%04b", ra), 8'(state_a), 8'(e));
    e = qb.pop_front(); chk($sformatf("b_req%04b", rb), 8'(state_b), 8'(e));
    e = qc.pop_front(); chk($sformatf("c_req%05b", rc), 8'(state_c), 8'(e));
    if (int'(state_c) > max_c) max_c = int'(state_c);
  endtask

  initial begin
    logic [1:0] exp_lut [16];
    exp_lut = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2,
                2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
    rst = 1'b1; req_a = '0; req_b = '0; req_c = '0;
    #1;
    chk("reset_a", 8'(state_a), 8'd1);
    chk("reset_b", 8'(state_b), 8'd3);
    chk("reset_c", 8'(state_c), 8'd4);
    for (int j = 0; j < 16; j++) begin
      $display("lut[%0d] = %0d", j, u_a.lut[j]);
      chk($sformatf("lut_a[%0d]", j), 8'(u_a.lut[j]), 8'(exp_lut[j]));
    end
    @(negedge clk);
    rst = 1'b0;

    // Sweep all request patterns against the reference model.
    for (int r = 0; r < 32; r++) begin
      step(r[3:0], m_next(r % 16, 1, 4), r[3:0], m_next(r % 16, 3, 4),
           r[4:0], m_next(r, 4, 5));
    end

    // Boundary and wrap-around cases.
    step(4'b1111, 2, 4'b1111, 0, 5'b11111, 0);
    step(4'b1000, 3, 4'b1000, 3, 5'b10000, 4);
    step(4'b0011, 0, 4'b1100, 2, 5'b01000, 3);
    step(4'b0000, 1, 4'b0000, 3, 5'b00000, 4);
    step(4'b0010, 1, 4'b0001, 0, 5'b00001, 0);

    // Asynchronous reset mid-cycle, then release.
    step(4'b0100, 2, 4'b0100, 2, 5'b00100, 2);
    step(4'b0100, 2, 4'b0100, 2, 5'b00100, 2);
    step(4'b0100, 2, 4'b0100, 2, 5'b00100, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", 8'(state_a), 8'd1);
    chk("async_rst_b", 8'(state_b), 8'd3);
    chk("async_rst_c", 8'(state_c), 8'd4);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release_hold_a", 8'(state_a), 8'd1);
    @(posedge clk);
    #1 chk("rst_release_load_a", 8'(state_a), 8'd2);
    @(negedge clk);

    // One-cycle latency on a request change just after the rising edge.
    step(4'b0001, 0, 4'b0001, 0, 5'b00001, 0);
    @(posedge clk);
    #1 req_a = 4'b1000;
    #1 chk("latency_hold_a", 8'(state_a), 8'd0);
    @(posedge clk);
    #1 chk("latency_load_a", 8'(state_a), 8'd3);
    @(negedge clk);

    n_total++;
    assert (max_c <= 4) n_pass++;
    else $error("FAIL c_state_range observed=%0d expected<=4", max_c);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
